// File: rtl/mul_pkg.sv
// Shared types and constants for the EX-stage multiply issue controller.
package mul_pkg;

  localparam int XLEN            = 32;
  localparam int REG_AW          = 5;
  localparam int MUL_LATENCY_DEF = 2;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] rd;
  } mul_req_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Issue, multiplier and writeback signals of the multiply issue controller.
interface mul_issue_ctrl_if;
  import mul_pkg::*;

  logic              issue_valid;
  logic [XLEN-1:0]   issue_a;
  logic [XLEN-1:0]   issue_b;
  logic [REG_AW-1:0] issue_rd;
  logic              flush;
  logic              issue_ready;
  logic              stall;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [XLEN-1:0]   mul_res;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  modport slave (
    input  issue_valid, issue_a, issue_b, issue_rd, flush, mul_res,
    output issue_ready, stall, mul_a, mul_b, wb_valid, wb_rd, wb_data
  );

  modport master (
    output issue_valid, issue_a, issue_b, issue_rd, flush, mul_res,
    input  issue_ready, stall, mul_a, mul_b, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/mul_op_cache.sv
// Last completed (a, b, product) triple; hit when both operands match a valid entry.
module mul_op_cache
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_a,
  input  logic [XLEN-1:0] load_b,
  input  logic [XLEN-1:0] load_p,
  input  logic [XLEN-1:0] chk_a,
  input  logic [XLEN-1:0] chk_b,
  output logic            hit,
  output logic [XLEN-1:0] prod
);

  logic            c_vld;
  logic [XLEN-1:0] c_a, c_b, c_p;

  // Only reset clears the valid bit; flush leaves the entry usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_p   <= '0;
    end else if (load) begin
      c_vld <= 1'b1;
      c_a   <= load_a;
      c_b   <= load_b;
      c_p   <= load_p;
    end
  end

  assign hit  = c_vld & (c_a == chk_a) & (c_b == chk_b);
  assign prod = c_p;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: holds operands on the multiplier, stalls for MUL_LATENCY
// edges, then strobes the product to writeback. Optional operand cache: MUL_OPCACHE_EN.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input logic        CLK,
  input logic        RSTn,
  mul_issue_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LATENCY);

  mul_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  mul_req_t          req_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              busy, accept, capture, hit;
  logic [XLEN-1:0]   cache_p;

  assign busy    = (state == ST_BUSY);
  assign accept  = bus.issue_valid & ~busy & ~bus.flush;
  assign capture = busy & (cnt == CNT_W'(1)) & ~bus.flush;

`ifdef MUL_OPCACHE_EN
  mul_op_cache u_cache (
    .clk    (CLK),
    .rst_n  (RSTn),
    .load   (capture),
    .load_a (req_q.a),
    .load_b (req_q.b),
    .load_p (bus.mul_res),
    .chk_a  (bus.issue_a),
    .chk_b  (bus.issue_b),
    .hit    (hit),
    .prod   (cache_p)
  );
`else
  assign hit     = 1'b0;
  assign cache_p = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BUSY: begin
        if (bus.flush)                  state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(1))      state_nxt = ST_DONE;
      end
      default: begin
        // DONE overlaps the next accept, so IDLE and DONE share this path.
        if (accept) state_nxt = hit ? ST_DONE : ST_BUSY;
        else        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !hit) begin
        cnt      <= LAT;
        req_q.a  <= bus.issue_a;
        req_q.b  <= bus.issue_b;
        req_q.rd <= bus.issue_rd;
      end else if (busy) begin
        cnt <= bus.flush ? '0 : cnt - CNT_W'(1);
      end
      if (capture) begin
        wb_data_q <= bus.mul_res;
        wb_rd_q   <= req_q.rd;
      end else if (accept && hit) begin
        wb_data_q <= cache_p;
        wb_rd_q   <= bus.issue_rd;
      end
    end
  end

  // Operands only move on a real (non-cached) accept, keeping the multiplier quiet.
  assign bus.mul_a       = req_q.a;
  assign bus.mul_b       = req_q.b;
  assign bus.issue_ready = ~busy;
  assign bus.stall       = busy | (bus.issue_valid & ~busy & ~hit);
  assign bus.wb_valid    = (state == ST_DONE);
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;

endmodule
